// File: rtl/event_arbiter_pkg.sv
// Shared record layout and readout FSM encoding for the event arbiter.
// Record: {unit id [15:14], event code [13:12], timestamp [11:0]}.
// No ports; imported by event_fifo and event_arbiter.
package event_arbiter_pkg;

    localparam int REC_W        = 16;
    localparam int UID_W        = 2;
    localparam int CODE_W       = 2;
    localparam int REC_TS_W     = 12;
    localparam int REC_UID_LSB  = 14;
    localparam int REC_CODE_LSB = 12;
    localparam int REC_TS_LSB   = 0;
    localparam int BYTE_W       = 8;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_MSB  = 2'd1,
        RD_LSB  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/event_fifo.sv
// Purpose: synchronous FIFO holding event records between arbiter and readout.
// Latency: push visible at the head one cycle later; full/empty from registered count.
// Backpressure: push ignored while full, pop ignored while empty.
// Ports: clk/rst_n, push_i + push_dat_i, pop_i, pop_dat_o (head), full_o, empty_o.
module event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_dat_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_dat_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o    = (cnt_q == CW'(DEPTH));
    assign empty_o   = (cnt_q == '0);
    assign push_ok   = push_i && !full_o;
    assign pop_ok    = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/event_arbiter.sv
// Purpose: timestamp per-unit spike events, round-robin them into a FIFO, read out as two bytes.
// Latency: spike -> slot next edge -> FIFO one edge later (when granted); read bytes one cycle after rd_req.
// Backpressure: full FIFO stalls grants (slots held); a spike on a still-pending slot is dropped and sets ovf.
// Ports: clk, rst_n, spike_in/event_in (per unit), rd_req, clear_ovf; rd_data, rd_valid, fifo_empty, fifo_full, ovf.
module event_arbiter
    import event_arbiter_pkg::*;
#(
    parameter int NUM_UNITS  = 2,
    parameter int TS_WIDTH   = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_UNITS-1:0]   spike_in,
    input  logic [2*NUM_UNITS-1:0] event_in,
    input  logic                   rd_req,
    input  logic                   clear_ovf,
    output logic [BYTE_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic                   ovf
);

    logic [TS_WIDTH-1:0]  ts_q;
    logic [REC_TS_W-1:0]  ts_rec;

    logic [NUM_UNITS-1:0] pending_q, pending_d;
    logic [CODE_W-1:0]    code_q  [NUM_UNITS];
    logic [CODE_W-1:0]    code_d  [NUM_UNITS];
    logic [REC_TS_W-1:0]  stamp_q [NUM_UNITS];
    logic [REC_TS_W-1:0]  stamp_d [NUM_UNITS];
    logic [UID_W-1:0]     last_q;

    logic                 gnt_vld;
    logic [UID_W-1:0]     gnt_idx;
    logic [REC_W-1:0]     push_dat;
    logic                 drop;
    logic                 ovf_q, ovf_d;

    rd_state_e            state_q, state_d;
    logic [BYTE_W-1:0]    rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 pop;
    logic [REC_W-1:0]     head_dat;
    logic                 fifo_full_w, fifo_empty_w;

    // Timestamp field is always 12 bits: truncate or zero-extend the counter.
    assign ts_rec = REC_TS_W'(ts_q);

    // Round-robin: first scan units above the last grant, then wrap to the rest.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        push_dat = '0;
        if (!fifo_full_w) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (!gnt_vld && pending_q[k] && (UID_W'(k) > last_q)) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = UID_W'(k);
                    push_dat = {UID_W'(k), code_q[k], stamp_q[k]};
                end
            end
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (!gnt_vld && pending_q[k] && (UID_W'(k) <= last_q)) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = UID_W'(k);
                    push_dat = {UID_W'(k), code_q[k], stamp_q[k]};
                end
            end
        end
    end

    // Slot update: a grant frees the slot in the same edge, so a new spike
    // arriving with the grant is captured rather than dropped.
    always_comb begin
        pending_d = pending_q;
        code_d    = code_q;
        stamp_d   = stamp_q;
        drop      = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (gnt_vld && (gnt_idx == UID_W'(k))) begin
                pending_d[k] = 1'b0;
            end
            if (spike_in[k]) begin
                if (!pending_q[k] || (gnt_vld && (gnt_idx == UID_W'(k)))) begin
                    pending_d[k] = 1'b1;
                    code_d[k]    = event_in[2*k +: 2];
                    stamp_d[k]   = ts_rec;
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    // A drop in the same cycle as clear_ovf wins so no loss goes unreported.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // Readout: the record is popped only when its second byte is taken.
    always_comb begin
        state_d    = state_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        pop        = 1'b0;
        case (state_q)
            RD_IDLE: begin
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
                if (rd_req && !fifo_empty_w) begin
                    state_d    = RD_MSB;
                    rd_data_d  = head_dat[REC_W-1 -: BYTE_W];
                    rd_valid_d = 1'b1;
                end
            end
            RD_MSB: begin
                if (rd_req) begin
                    state_d    = RD_LSB;
                    rd_data_d  = head_dat[BYTE_W-1:0];
                    rd_valid_d = 1'b1;
                    pop        = 1'b1;
                end
            end
            RD_LSB: begin
                state_d    = RD_IDLE;
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
            end
            default: begin
                state_d    = RD_IDLE;
                rd_data_d  = '0;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q       <= '0;
            pending_q  <= '0;
            last_q     <= UID_W'(NUM_UNITS - 1);
            ovf_q      <= 1'b0;
            state_q    <= RD_IDLE;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            for (int k = 0; k < NUM_UNITS; k++) begin
                code_q[k]  <= '0;
                stamp_q[k] <= '0;
            end
        end else begin
            ts_q       <= ts_q + TS_WIDTH'(1);
            pending_q  <= pending_d;
            code_q     <= code_d;
            stamp_q    <= stamp_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            if (gnt_vld) begin
                last_q <= gnt_idx;
            end
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (gnt_vld),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .full_o     (fifo_full_w),
        .empty_o    (fifo_empty_w)
    );

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign fifo_empty = fifo_empty_w;
    assign fifo_full  = fifo_full_w;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_event_arbiter.sv
// Purpose: self-checking bench for event_arbiter against a queue-based reference model.
// Latency: inputs driven after the falling edge, outputs sampled on the next falling edge.
// Backpressure: exercised by filling the FIFO and forcing drops on a held slot.
module tb_event_arbiter;

    localparam int N     = 2;
    localparam int TSW   = 12;
    localparam int DEPTH = 8;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [N-1:0]   spike_in  = '0;
    logic [2*N-1:0] event_in  = '0;
    logic           rd_req    = 1'b0;
    logic           clear_ovf = 1'b0;
    logic [7:0]     rd_data;
    logic           rd_valid;
    logic           fifo_empty;
    logic           fifo_full;
    logic           ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    event_arbiter #(
        .NUM_UNITS  (N),
        .TS_WIDTH   (TSW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .event_in   (event_in),
        .rd_req     (rd_req),
        .clear_ovf  (clear_ovf),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .ovf        (ovf)
    );

    // Reference model: records as a queue, slots as prebuilt records,
    // readout as a byte phase (0 idle, 1 high byte shown, 2 low byte shown).
    int          m_ts;
    bit          m_pend [N];
    logic [15:0] m_rec  [N];
    logic [15:0] m_q    [$];
    int          m_last;
    int          m_phase;
    logic [7:0]  m_data;
    bit          m_valid;
    bit          m_ovf;

    always @(posedge clk or negedge rst_n) begin : model
        int          g;
        int          u;
        int          sz;
        bit          lost;
        if (!rst_n) begin
            m_ts    = 0;
            m_last  = N - 1;
            m_phase = 0;
            m_data  = 8'h00;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_q.delete();
            for (int k = 0; k < N; k++) begin
                m_pend[k] = 1'b0;
                m_rec[k]  = 16'h0;
            end
        end else begin
            sz = m_q.size();
            g  = -1;
            if (sz < DEPTH) begin
                for (int i = 1; i <= N; i++) begin
                    u = (m_last + i) % N;
                    if (g < 0 && m_pend[u]) g = u;
                end
            end
            case (m_phase)
                0: begin
                    if (rd_req && sz > 0) begin
                        m_phase = 1;
                        m_data  = m_q[0][15:8];
                        m_valid = 1'b1;
                    end else begin
                        m_data  = 8'h00;
                        m_valid = 1'b0;
                    end
                end
                1: begin
                    if (rd_req) begin
                        m_phase = 2;
                        m_data  = m_q[0][7:0];
                        void'(m_q.pop_front());
                    end
                end
                default: begin
                    m_phase = 0;
                    m_data  = 8'h00;
                    m_valid = 1'b0;
                end
            endcase
            if (g >= 0) begin
                m_q.push_back(m_rec[g]);
                m_pend[g] = 1'b0;
                m_last    = g;
            end
            lost = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (spike_in[k]) begin
                    if (!m_pend[k]) begin
                        m_pend[k] = 1'b1;
                        m_rec[k]  = {k[1:0], event_in[2*k +: 2], m_ts[11:0]};
                    end else begin
                        lost = 1'b1;
                    end
                end
            end
            if (lost)           m_ovf = 1'b1;
            else if (clear_ovf) m_ovf = 1'b0;
            m_ts = (m_ts + 1) % (1 << TSW);
        end
    end

    task automatic step(input logic [N-1:0] spk, input logic [2*N-1:0] evt,
                        input logic rd, input logic clr);
        spike_in  = spk;
        event_in  = evt;
        rd_req    = rd;
        clear_ovf = clr;
        @(posedge clk);
        @(negedge clk);
        spike_in  = '0;
        rd_req    = 1'b0;
        clear_ovf = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Three cycles: high byte, low byte (pop), return to idle.
    task automatic read_rec(output logic [15:0] rec, output logic ok);
        step('0, '0, 1'b1, 1'b0);
        rec[15:8] = rd_data;
        ok        = rd_valid;
        step('0, '0, 1'b1, 1'b0);
        rec[7:0]  = rd_data;
        ok        = ok & rd_valid;
        step('0, '0, 1'b0, 1'b0);
        ok        = ok & !rd_valid & (rd_data == 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({rd_data, rd_valid, fifo_empty, fifo_full, ovf} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h v=%b e=%b f=%b o=%b, want 00 0 1 0 0",
                     rd_data, rd_valid, fifo_empty, fifo_full, ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [15:0] rec;
        logic        ok;
        do_reset();
        for (int i = 0; i < 100 && m_ts != 5; i++) step('0, '0, 1'b0, 1'b0);
        step(2'b01, 4'b0010, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        n_chk++;
        if (fifo_empty !== 1'b0) begin
            n_fail++;
            $display("FAIL single_not_empty: got %b want 0", fifo_empty);
        end
        read_rec(rec, ok);
        n_chk++;
        if (rec !== 16'h2005 || !ok) begin
            n_fail++;
            $display("FAIL single_bytes: got %h valid_ok=%b want 2005 valid_ok=1", rec, ok);
        end
        n_chk++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL single_empty_after: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_simul_rr();
        logic [15:0] rec;
        logic [15:0] exp;
        logic        ok;
        logic [3:0]  want_nib [4];
        want_nib[0] = 4'h1;   // unit 0, code 1
        want_nib[1] = 4'h7;   // unit 1, code 3
        want_nib[2] = 4'h2;   // unit 0 again first, code 2
        want_nib[3] = 4'h4;   // unit 1, code 0
        do_reset();
        step(2'b11, 4'b1101, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) begin
            if (r == 2) begin
                step(2'b11, 4'b0010, 1'b0, 1'b0);
                step('0, '0, 1'b0, 1'b0);
                step('0, '0, 1'b0, 1'b0);
            end
            exp = (m_q.size() > 0) ? m_q[0] : 16'hxxxx;
            read_rec(rec, ok);
            n_chk++;
            if (rec[15:12] !== want_nib[r] || rec !== exp || !ok) begin
                n_fail++;
                $display("FAIL simul_rr[%0d]: got %h ok=%b want id/code %h record %h", r, rec, ok, want_nib[r], exp);
            end
        end
    endtask

    task automatic test_full_drop();
        logic [15:0] rec;
        logic [15:0] exp;
        logic        ok;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(2'b01, {2'b00, 2'(i % 4)}, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        n_chk++;
        if ({fifo_full, ovf} !== 2'b10) begin
            n_fail++;
            $display("FAIL full_after_8: got full=%b ovf=%b want 1 0", fifo_full, ovf);
        end
        step(2'b01, 4'b0011, 1'b0, 1'b0);    // held pending while full
        step(2'b01, 4'b0001, 1'b0, 1'b0);    // dropped
        n_chk++;
        if ({fifo_full, ovf} !== 2'b11) begin
            n_fail++;
            $display("FAIL drop_sets_ovf: got full=%b ovf=%b want 1 1", fifo_full, ovf);
        end
        step(2'b01, 4'b0010, 1'b0, 1'b1);    // drop together with clear
        n_chk++;
        if (ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_and_clear: got ovf=%b want 1", ovf);
        end
        step('0, '0, 1'b0, 1'b1);
        n_chk++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ovf: got ovf=%b want 0", ovf);
        end
        read_rec(rec, ok);
        n_chk++;
        if (fifo_full !== 1'b1 || rec !== 16'h0000 || !ok) begin
            n_fail++;
            $display("FAIL refill_after_pop: got full=%b rec=%h ok=%b want 1 0000 1", fifo_full, rec, ok);
        end
        for (int r = 0; r < DEPTH; r++) begin
            exp = (m_q.size() > 0) ? m_q[0] : 16'hxxxx;
            read_rec(rec, ok);
            n_chk++;
            if (rec !== exp || !ok || (r == DEPTH - 1 && rec[13:12] !== 2'b11)) begin
                n_fail++;
                $display("FAIL drain[%0d]: got %h ok=%b want %h", r, rec, ok, exp);
            end
        end
        n_chk++;
        if (fifo_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL drained_empty: got %b want 1", fifo_empty);
        end
    endtask

    task automatic test_empty_read();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step('0, '0, 1'b1, 1'b0);
            n_chk++;
            if ({rd_data, rd_valid, fifo_empty} !== {8'h00, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL empty_read[%0d]: got data=%h v=%b e=%b want 00 0 1", i, rd_data, rd_valid, fifo_empty);
            end
        end
    endtask

    task automatic test_wrap_and_reset();
        logic [15:0] rec;
        logic        ok;
        do_reset();
        for (int i = 0; i < 5000 && m_ts != 4095; i++) step('0, '0, 1'b0, 1'b0);
        step(2'b01, 4'b0001, 1'b0, 1'b0);    // ts = 0xFFF
        step(2'b01, 4'b0010, 1'b0, 1'b0);    // ts = 0x000, granted same cycle
        step('0, '0, 1'b0, 1'b0);
        read_rec(rec, ok);
        n_chk++;
        if (rec !== 16'h1FFF || !ok) begin
            n_fail++;
            $display("FAIL wrap_first: got %h ok=%b want 1fff", rec, ok);
        end
        read_rec(rec, ok);
        n_chk++;
        if (rec !== 16'h2000 || !ok) begin
            n_fail++;
            $display("FAIL wrap_second: got %h ok=%b want 2000", rec, ok);
        end
        step(2'b10, 4'b1100, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b1, 1'b0);
        n_chk++;
        if (rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL msb_before_reset: got v=%b want 1", rd_valid);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({rd_data, rd_valid, fifo_empty, fifo_full, ovf} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_read: got data=%h v=%b e=%b f=%b o=%b want 00 0 1 0 0",
                     rd_data, rd_valid, fifo_empty, fifo_full, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [N-1:0]   spk;
        logic [2*N-1:0] evt;
        logic           rd;
        logic           clr;
        int             bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) spk[k] = ($urandom_range(0, 99) < 35);
            evt = N*2'($urandom);
            rd  = ($urandom_range(0, 99) < 45);
            clr = ($urandom_range(0, 99) < 5);
            step(spk, evt, rd, clr);
            n_chk++;
            if ({rd_data, rd_valid, fifo_empty, fifo_full, ovf} !==
                {m_data, m_valid, m_q.size() == 0, m_q.size() == DEPTH, m_ovf}) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random[%0d]: got data=%h v=%b e=%b f=%b o=%b want %h %b %b %b %b",
                             c, rd_data, rd_valid, fifo_empty, fifo_full, ovf,
                             m_data, m_valid, m_q.size() == 0, m_q.size() == DEPTH, m_ovf);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_simul_rr();
        test_full_drop();
        test_empty_read();
        test_wrap_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/event_arbiter.md
EVENT_ARBITER -- requirements
Module: event_arbiter

Interface
REQ-001 Parameter NUM_UNITS, default 2, number of spike/event sources (1..4).
REQ-002 Parameter TS_WIDTH, default 12, timestamp counter width.
REQ-003 Parameter FIFO_DEPTH, default 8, event FIFO entries (power of two).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 spike_in  input  NUM_UNITS  per-unit spike strobe, one cycle per event.
REQ-007 event_in  input  2*NUM_UNITS  per-unit 2-bit event code; unit k at [2k+1:2k].
REQ-008 rd_req  input  1  single-cycle read strobe from host byte port.
REQ-009 clear_ovf  input  1  clears overflow sticky flag.
REQ-010 rd_data  output  8  readout byte.
REQ-011 rd_valid  output  1  rd_data holds a valid byte.
REQ-012 fifo_empty  output  1  no stored records.
REQ-013 fifo_full  output  1  FIFO holds FIFO_DEPTH records.
REQ-014 ovf  output  1  sticky: at least one event dropped.

Function
REQ-015 Free-running TS_WIDTH counter increments every cycle, wraps from all-ones to 0.
REQ-016 spike_in[k]=1: set pending[k], latch event code and current timestamp into unit k slot.
REQ-017 spike_in[k]=1 while pending[k]=1 and not granted that cycle: new event dropped, slot kept, ovf set.
REQ-018 Grant and new spike on unit k in same cycle: old slot pushed, new event captured; no drop.
REQ-019 Each cycle with FIFO not full: round-robin grant to one pending unit, starting after the last-granted unit; push 16-bit record, clear pending.
REQ-020 Record = {unit id [15:14], event code [13:12], timestamp [11:0]}; timestamp truncated/zero-extended to 12 bits.
REQ-021 FIFO full: no grant; pending slots held, not dropped.
REQ-022 Readout FSM states IDLE, MSB, LSB.
REQ-023 IDLE + rd_req + FIFO not empty -> MSB; next cycle rd_data=record[15:8], rd_valid=1.
REQ-024 MSB + rd_req -> LSB; next cycle rd_data=record[7:0], rd_valid=1; record popped on this transition.
REQ-025 LSB -> IDLE after one cycle; rd_req in LSB state ignored.
REQ-026 rd_req in IDLE with FIFO empty: stay IDLE, rd_valid=0, rd_data=0.
REQ-027 rd_valid=0 and rd_data=0 in IDLE; in MSB, byte held until next rd_req.
REQ-028 Push and pop in same cycle: both take effect; occupancy unchanged.
REQ-029 clear_ovf clears ovf; simultaneous drop and clear_ovf leaves ovf=1.
REQ-030 fifo_empty/fifo_full reflect registered occupancy, update cycle after push/pop.

Reset
REQ-031 rst_n low: timestamp, pending, slots, round-robin pointer (last-granted = NUM_UNITS-1), FIFO pointers, ovf cleared.
REQ-032 Reset outputs: rd_data=0, rd_valid=0, fifo_empty=1, fifo_full=0, ovf=0; FSM IDLE.
REQ-033 Reset mid-readout discards partially read record; no pop.

Structure
REQ-034 Package event_arbiter_pkg: record field offsets/widths, unit-id width, readout FSM state enum.
REQ-035 Sub-module event_fifo: synchronous FIFO, 16-bit width, FIFO_DEPTH entries, push/pop/full/empty.
REQ-036 Arbiter, capture slots, timestamp and readout FSM in event_arbiter top.

Verification
REQ-037 Reset release, spike_in=01, event_in=0010 at ts=5 -> two rd_req yield 0x20, 0x05; fifo_empty=1 afterwards.
REQ-038 spike_in=11 same cycle, codes 1/3 -> unit 0 record pushed first, then unit 1; second grant round-robins to unit 0.
REQ-039 Unit 0 spikes on two consecutive cycles while FIFO full -> second dropped, ovf=1; clear_ovf -> ovf=0.
REQ-040 Push 8 records without reading -> fifo_full=1; further spikes stay pending, pushed after one record popped.
REQ-041 rd_req with FIFO empty -> rd_valid stays 0, rd_data=0x00, FSM IDLE.
REQ-042 Timestamp wrap: spike at ts=0xFFF then next cycle -> records carry 0xFFF and 0x000; rst_n low during MSB -> outputs zero, FIFO empty.
